// File: rtl/mult_fu_pkg.sv
// Shared types for the pipelined RV32M multiply unit and its CDB slot.
package mult_fu_pkg;

  localparam int unsigned ROB_CNT_WIDTH   = 5;
  localparam int unsigned PRN_WIDTH       = 6;
  // Pipeline depth; must be 1, 2, 4 or 8 so the 64-bit multiplier splits evenly.
  localparam int unsigned NUM_MULT_STAGES = 4;

  typedef logic [ROB_CNT_WIDTH-1:0] ROBN;
  typedef logic [PRN_WIDTH-1:0]     PRN;
  typedef logic [31:0]              DATA;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } MULT_FUNC;

  // Same layout as the CDB's mult_packet.
  typedef struct packed {
    ROBN robn;
    PRN  dest_prn;
    DATA result;
  } MULT_PACKET;

  typedef struct packed {
    logic        valid;
    MULT_FUNC    func;
    ROBN         robn;
    PRN          dest_prn;
    logic [63:0] mcand;
    logic [63:0] mplier;
    logic [63:0] product;
  } MULT_STAGE_PACKET;

  // MUL returns the low word, every high-half variant returns the upper word.
  function automatic DATA mult_select(input MULT_FUNC func, input logic [63:0] product);
    return (func == MUL) ? product[31:0] : product[63:32];
  endfunction

endpackage

// File: rtl/mult_fu_stage.sv
// One combinational slice of the multiply: adds mcand * (one CHUNK-wide multiplier digit).
module mult_stage
  import mult_fu_pkg::*;
#(
  parameter int unsigned CHUNK     = 16,
  parameter int unsigned STAGE_IDX = 0
) (
  input  MULT_STAGE_PACKET in_pkt,
  output MULT_STAGE_PACKET out_pkt
);

  localparam int unsigned LSB = STAGE_IDX * CHUNK;

  logic [CHUNK-1:0] digit;
  logic [63:0]      partial;

  // Accumulate this stage's partial product; everything else rides along unchanged.
  always_comb begin
    digit           = in_pkt.mplier[LSB +: CHUNK];
    partial         = (in_pkt.mcand << LSB) * 64'(digit);
    out_pkt         = in_pkt;
    out_pkt.product = in_pkt.product + partial;
  end

endmodule

// File: rtl/mult_fu.sv
// Pipelined RV32M multiply unit feeding one CDB mult slot; global stall on a refused result.
module mult_fu
  import mult_fu_pkg::*;
#(
  parameter int unsigned NUM_STAGES = NUM_MULT_STAGES
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         squash,
  input  logic         valid_in,
  input  MULT_FUNC     func_in,
  input  ROBN          robn_in,
  input  PRN           dest_prn_in,
  input  DATA          rs1_in,
  input  DATA          rs2_in,
  input  logic         cdb_avail,
  output logic         ready_out,
  output logic         prepared,
  output MULT_PACKET   out_packet
);

  localparam int unsigned CHUNK    = 64 / NUM_STAGES;
  // Stage N-1 feeds the output register directly, so only N-1 inter-stage registers exist.
  localparam int unsigned NUM_REGS = (NUM_STAGES > 1) ? NUM_STAGES - 1 : 1;

  MULT_STAGE_PACKET issue_pkt;
  MULT_STAGE_PACKET stage_in  [NUM_STAGES];
  MULT_STAGE_PACKET stage_out [NUM_STAGES];
  MULT_STAGE_PACKET pipe_q    [NUM_REGS];
  logic             prepared_q;
  MULT_PACKET       out_q;
  logic             advance;

  // Output is free to move whenever it is empty or the CDB takes it this cycle.
  assign advance    = ~prepared_q | cdb_avail;
  assign ready_out  = advance;
  assign prepared   = prepared_q;
  assign out_packet = out_q;

  // Sign/zero-extend the operands to 64 bits so a modulo-2^64 product covers every variant.
  always_comb begin
    issue_pkt          = '0;
    issue_pkt.valid    = valid_in;
    issue_pkt.func     = func_in;
    issue_pkt.robn     = robn_in;
    issue_pkt.dest_prn = dest_prn_in;
    issue_pkt.mcand    = (func_in == MULHU) ? {32'd0, rs1_in} : {{32{rs1_in[31]}}, rs1_in};
    issue_pkt.mplier   = (func_in == MUL || func_in == MULH) ? {{32{rs2_in[31]}}, rs2_in}
                                                             : {32'd0, rs2_in};
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign stage_in[k] = issue_pkt;
    end else begin : g_rest
      assign stage_in[k] = pipe_q[k-1];
    end

    mult_stage #(
      .CHUNK     (CHUNK),
      .STAGE_IDX (k)
    ) u_stage (
      .in_pkt  (stage_in[k]),
      .out_pkt (stage_out[k])
    );
  end

  // Pipeline and output registers: reset > squash > advance; otherwise everything holds.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < int'(NUM_REGS); k++) begin
        pipe_q[k] <= '0;
      end
      prepared_q <= 1'b0;
      out_q      <= '0;
    end else if (squash) begin
      for (int k = 0; k < int'(NUM_REGS); k++) begin
        pipe_q[k].valid <= 1'b0;
      end
      prepared_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < int'(NUM_STAGES) - 1; k++) begin
        pipe_q[k] <= stage_out[k];
      end
      prepared_q     <= stage_out[NUM_STAGES-1].valid;
      out_q.robn     <= stage_out[NUM_STAGES-1].robn;
      out_q.dest_prn <= stage_out[NUM_STAGES-1].dest_prn;
      out_q.result   <= mult_select(stage_out[NUM_STAGES-1].func,
                                    stage_out[NUM_STAGES-1].product);
    end
  end

endmodule

// File: tb/tb_mult_fu.sv
// Scoreboard bench for mult_fu: stimulus pushes expected packets, a negedge monitor pops them.
module tb_mult_fu;
  import mult_fu_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       squash;
  logic       valid_in;
  MULT_FUNC   func_in;
  ROBN        robn_in;
  PRN         dest_prn_in;
  DATA        rs1_in;
  DATA        rs2_in;
  logic       cdb_avail;
  logic       ready_out;
  logic       prepared;
  MULT_PACKET out_packet;

  int n_tests = 0;
  int n_fail  = 0;

  MULT_PACKET exp_q[$];
  MULT_PACKET held;
  logic       stall_prev = 1'b0;
  ROBN        robn_ctr   = '0;

  mult_fu #(.NUM_STAGES(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .squash      (squash),
    .valid_in    (valid_in),
    .func_in     (func_in),
    .robn_in     (robn_in),
    .dest_prn_in (dest_prn_in),
    .rs1_in      (rs1_in),
    .rs2_in      (rs2_in),
    .cdb_avail   (cdb_avail),
    .ready_out   (ready_out),
    .prepared    (prepared),
    .out_packet  (out_packet)
  );

  always #5 clock = ~clock;

  // Reference: exact 64-bit products from plain integer arithmetic.
  function automatic DATA ref_mult(input MULT_FUNC f, input DATA a, input DATA b);
    longint          sa, sb;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      MUL:     begin p = sa * sb;           return p[31:0];  end
      MULH:    begin p = sa * sb;           return p[63:32]; end
      MULHSU:  begin p = sa * longint'(ub); return p[63:32]; end
      default: begin p = ua * ub;           return p[63:32]; end
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: consume/compare on handshake, hold check on stall, accept-push on issue.
  always @(negedge clock) begin
    if (reset || squash) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      n_tests++;
      if (ready_out !== (!prepared || cdb_avail)) begin
        n_fail++;
        $display("FAIL ready_out: got %b, expected %b", ready_out, (!prepared || cdb_avail));
      end
      if (stall_prev) begin
        n_tests++;
        if (prepared !== 1'b1 || out_packet !== held) begin
          n_fail++;
          $display("FAIL stall_hold: got prep=%b pkt=%h, expected prep=1 pkt=%h",
                   prepared, out_packet, held);
        end
      end
      if (prepared && cdb_avail) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: got pkt=%h, expected none", out_packet);
        end else begin
          MULT_PACKET e;
          e = exp_q.pop_front();
          if (out_packet !== e) begin
            n_fail++;
            $display("FAIL result: got robn=%h prn=%h res=%h, expected robn=%h prn=%h res=%h",
                     out_packet.robn, out_packet.dest_prn, out_packet.result,
                     e.robn, e.dest_prn, e.result);
          end
        end
      end
      stall_prev = prepared && !cdb_avail;
      held       = out_packet;
      if (valid_in && ready_out) begin
        MULT_PACKET e;
        e.robn     = robn_in;
        e.dest_prn = dest_prn_in;
        e.result   = ref_mult(func_in, rs1_in, rs2_in);
        exp_q.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input MULT_FUNC f, input DATA a, input DATA b);
    valid_in    = v;
    func_in     = f;
    robn_in     = robn_ctr;
    dest_prn_in = PRN'($urandom);
    rs1_in      = a;
    rs2_in      = b;
    robn_ctr++;
  endtask

  task automatic issue(input MULT_FUNC f, input DATA a, input DATA b);
    drive(1'b1, f, a, b);
    step();
    valid_in = 1'b0;
  endtask

  // Counts cycles from an issue (which already spent one) until prepared rises.
  task automatic wait_prepared(output int n);
    n = 1;
    while (!prepared && n < 20) begin
      step();
      n++;
    end
  endtask

  function automatic DATA pick();
    DATA corners [6];
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0001_0000};
    if ($urandom_range(0, 2) == 0) return corners[$urandom_range(0, 5)];
    return DATA'($urandom);
  endfunction

  initial begin
    int n;
    reset = 1'b1; squash = 1'b0; valid_in = 1'b0; cdb_avail = 1'b0;
    func_in = MUL; robn_in = '0; dest_prn_in = '0; rs1_in = '0; rs2_in = '0;
    repeat (3) step();
    reset = 1'b0;
    #1;
    check("reset_prepared", prepared, 0);
    check("reset_out_packet", out_packet, 0);
    check("reset_ready", ready_out, 1);

    // Single MUL with latency check.
    cdb_avail = 1'b1;
    issue(MUL, 32'd7, 32'd6);
    wait_prepared(n);
    check("single_latency", n, 4);
    check("single_result", out_packet.result, 42);
    step();
    check("single_prepared_drop", prepared, 0);

    // Back-to-back, results on consecutive cycles.
    issue(MUL, 32'hFFFF_FFFD, 32'd5);
    issue(MULH, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(MULHSU, 32'hFFFF_FFFF, 32'd2);
    issue(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) begin
      check("b2b_prepared", prepared, 1);
      step();
    end
    check("b2b_drain", prepared, 0);

    // Back-pressure: stall three cycles with junk valid_in that must be ignored.
    issue(MUL, 32'd3, 32'd9);
    issue(MULHU, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(MULHSU, 32'h8000_0000, 32'hFFFF_FFFF);
    cdb_avail = 1'b0;
    drive(1'b1, MUL, 32'd1, 32'd1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_ready", ready_out, 0);
      step();
    end
    valid_in  = 1'b0;
    cdb_avail = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("release_prepared", prepared, 1);
      step();
    end
    check("release_drain", prepared, 0);

    // Squash with a stalled output and three ops behind it.
    cdb_avail = 1'b0;
    issue(MUL, 32'd11, 32'd12);
    issue(MUL, 32'd13, 32'd14);
    issue(MUL, 32'd15, 32'd16);
    issue(MUL, 32'd17, 32'd18);
    check("pre_squash_prepared", prepared, 1);
    squash = 1'b1;
    drive(1'b1, MULHU, 32'd5, 32'd5);
    step();
    squash    = 1'b0;
    cdb_avail = 1'b1;
    check("squash_prepared", prepared, 0);
    issue(MULHSU, 32'h8000_0000, 32'h0000_0003);
    wait_prepared(n);
    check("post_squash_latency", n, 4);
    step();

    // Reset mid-stream with a result waiting.
    cdb_avail = 1'b0;
    issue(MULH, 32'h1234_5678, 32'h9ABC_DEF0);
    issue(MUL, 32'd100, 32'd200);
    wait_prepared(n);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset_prepared", prepared, 0);
    check("midreset_out_packet", out_packet, 0);
    check("midreset_ready", ready_out, 1);
    cdb_avail = 1'b1;
    issue(MULHU, 32'hDEAD_BEEF, 32'h0000_0010);
    wait_prepared(n);
    check("post_reset_latency", n, 4);

    // Randomized traffic with random back-pressure and occasional squash.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, MULT_FUNC'($urandom_range(0, 3)), pick(), pick());
      cdb_avail = ($urandom_range(0, 9) < 7);
      squash    = ($urandom_range(0, 79) == 0);
      step();
    end
    valid_in  = 1'b0;
    squash    = 1'b0;
    cdb_avail = 1'b1;
    repeat (10) step();
    check("drain_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mult_fu.md
Name: mult_fu

Overview:
- Pipelined integer multiply functional unit for RV32M MUL/MULH/MULHSU/MULHU.
- Sits between the multiply reservation-station issue port and one CDB mult input slot, i.e. directly upstream of the CDB.
- Exposes a prepared/packet output that the CDB latches; the CDB's per-slot avail bit back-pressures it.
- Fully pipelined: throughput 1 op/cycle. Global stall while a finished result is refused.

Parameters:
- NUM_STAGES, 4, pipeline depth (latency). Must be 1, 2, 4 or 8 (divides 64).
- CHUNK, 64/NUM_STAGES, multiplier bits consumed per stage (derived, not overridable).

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- squash  in  1  mispredict flush; kills all in-flight ops
- valid_in  in  1  RS issues an op this cycle
- func_in  in  MULT_FUNC (2)  MUL=0, MULH=1, MULHSU=2, MULHU=3
- robn_in  in  ROB_CNT_WIDTH  ROB tag
- dest_prn_in  in  PRN_WIDTH  destination physical reg
- rs1_in  in  32  multiplicand source
- rs2_in  in  32  multiplier source
- cdb_avail  in  1  CDB mult_avail bit for this slot
- ready_out  out  1  op presented this cycle is accepted
- prepared  out  1  output packet valid (to fu_state_packet.mult_prepared)
- out_packet  out  MULT_PACKET  {robn, dest_prn, result[31:0]}

Behaviour:
- Reset: all stage valids 0, payloads 0, prepared=0, out_packet=0, ready_out=1.
- advance = ~prepared | cdb_avail. ready_out = advance (combinational; cdb_avail comes from CDB registered state, so no loop).
- On advance: every stage shifts one step. Stage 0 loads the issue op when valid_in. The final stage writes the output register; prepared takes the final stage's valid.
- On ~advance: all stages and the output hold. valid_in is ignored and the RS must retry.
- Latency: accepted at cycle t -> prepared=1 at t+NUM_STAGES (no stalls). Each stall cycle adds 1.
- Operand extension to 64 bits:
  - MUL and MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU: both operands unsigned.
- Stage k:
  - Adds (mcand << (k*CHUNK)) * mplier[k*CHUNK +: CHUNK] to the 64-bit running product. Arithmetic is modulo 2^64.
  - Carries mcand, mplier, func, robn and dest_prn forward with the running product.
- result = MUL ? product[31:0] : product[63:32].
- squash (synchronous): clears every stage valid and prepared next cycle. valid_in in the squash cycle is discarded. Payloads are don't-care. The squash cycle's ready_out value is don't-care for the RS.
- Simultaneous cdb_avail=1 and prepared=1: the old result is consumed and the next result (or a bubble) loads in the same edge. No duplicate is presented and no result is lost.
- Bubbles still advance when advance=1. There is no bubble collapsing; the stall is global.
- reset has priority over squash, and squash has priority over advance.
- Corner values are exact:
  - 0x80000000 * 0xFFFFFFFF: MULH = 0x00000000, MUL = 0x80000000.
  - MULHU of the same operands = 0x7FFFFFFF.

Decomposition:
- sys_defs additions:
  - MULT_FUNC enum.
  - MULT_PACKET {ROBN robn; PRN dest_prn; DATA result} (shared with the CDB's mult_packet).
  - MULT_STAGE_PACKET {valid, func, robn, dest_prn, mcand[63:0], mplier[63:0], product[63:0]}.
  - NUM_MULT_STAGES define feeding NUM_STAGES.
- Sub-module mult_stage:
  - Combinational, parameterised by CHUNK and stage index.
  - Takes a MULT_STAGE_PACKET and returns the accumulated MULT_STAGE_PACKET.
- mult_fu holds the registers, stall/squash control, and generate loop.

Test Plan:
- Single MUL 7*6, cdb_avail=1 held: prepared=1 exactly 4 cycles after issue; result=42; robn and dest_prn echoed; prepared=0 next cycle.
- Back-to-back: 4 ops issued on consecutive cycles (MUL -3*5, MULH 0x80000000*0xFFFFFFFF, MULHSU 0xFFFFFFFF*2, MULHU 0xFFFFFFFF*0xFFFFFFFF):
  - Results 0xFFFFFFF1, 0, 0xFFFFFFFF, 0xFFFFFFFE on consecutive cycles, in issue order.
- Back-pressure: hold cdb_avail=0 for 3 cycles once prepared=1 with 3 more ops in flight:
  - ready_out=0 and the output is stable throughout.
  - On release, all 4 results appear once each, in order, with no gaps beyond the stall.
- Simultaneous consume/load: cdb_avail=1 on the same cycle a new result reaches the output -> prepared stays 1 and the new robn replaces the old one with no repeat.
- squash with 3 ops in flight and a stalled output -> prepared=0 next cycle; no squashed robn ever appears; an op issued the cycle after squash completes normally at t+4.
- Reset asserted mid-stream with prepared=1 -> prepared=0, out_packet=0, ready_out=1 the next cycle; a subsequent op completes with correct latency.
